// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder: FSM state encoding and counter sizing.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit counter width; a one-bit operand still needs a one-bit counter.
    function automatic int unsigned cnt_w(input int unsigned width);
        return (width > 1) ? 32'($clog2(width)) : 32'd1;
    endfunction

endpackage

// File: rtl/serial_adder_adder.sv
// One-bit full-adder cell used by serial_adder for its per-bit sum and carry.
module adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, LSB first, one bit per clock with a registered carry.
// Define SERIAL_ADDER_OVERFLOW_EN to add the signed-overflow output.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    localparam int unsigned CW = cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [CW-1:0]    cnt;
    logic             bit_sum;
    logic             bit_cout;

    // cout doubles as the running carry register between bit steps.
    adder u_adder (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .cin  (cout),
        .sum  (bit_sum),
        .cout (bit_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            cnt       <= '0;
            sum       <= '0;
            cout      <= 1'b0;
`ifdef SERIAL_ADDER_OVERFLOW_EN
            overflow  <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        state    <= RUN;
                        in_ready <= 1'b0;
                        a_q      <= a;
                        b_q      <= b;
                        cout     <= cin;
                        cnt      <= '0;
                        sum      <= '0;
                    end
                end
                RUN: begin
                    sum  <= WIDTH'({bit_sum, sum} >> 1);
                    a_q  <= WIDTH'(a_q >> 1);
                    b_q  <= WIDTH'(b_q >> 1);
                    cout <= bit_cout;
                    cnt  <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
`ifdef SERIAL_ADDER_OVERFLOW_EN
                        // Carry into the MSB versus carry out of it.
                        overflow  <= cout ^ bit_cout;
`endif
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
`ifdef SERIAL_ADDER_OVERFLOW_EN
                        overflow  <= 1'b0;
`endif
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Randomized and directed checks of serial_adder at WIDTH 8, 3 and 1 against an arithmetic model.
module tb_serial_adder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic       in_valid8, in_ready8, out_valid8, out_ready8, cin8, cout8, ovf8;
    logic [7:0] a8, b8, sum8;
    logic       in_valid3, in_ready3, out_valid3, out_ready3, cin3, cout3, ovf3;
    logic [2:0] a3, b3, sum3;
    logic       in_valid1, in_ready1, out_valid1, out_ready1, cin1, cout1, ovf1;
    logic [0:0] a1, b1, sum1;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .cin(cin8), .out_valid(out_valid8), .out_ready(out_ready8),
        .sum(sum8), .cout(cout8)
`ifdef SERIAL_ADDER_OVERFLOW_EN
        , .overflow(ovf8)
`endif
    );

    serial_adder #(.WIDTH(3)) dut3 (
        .clk(clk), .rst(rst), .in_valid(in_valid3), .in_ready(in_ready3),
        .a(a3), .b(b3), .cin(cin3), .out_valid(out_valid3), .out_ready(out_ready3),
        .sum(sum3), .cout(cout3)
`ifdef SERIAL_ADDER_OVERFLOW_EN
        , .overflow(ovf3)
`endif
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .cin(cin1), .out_valid(out_valid1), .out_ready(out_ready1),
        .sum(sum1), .cout(cout1)
`ifdef SERIAL_ADDER_OVERFLOW_EN
        , .overflow(ovf1)
`endif
    );

`ifndef SERIAL_ADDER_OVERFLOW_EN
    assign ovf8 = 1'b0;
    assign ovf3 = 1'b0;
    assign ovf1 = 1'b0;
`endif

    // Signed overflow from two's-complement value ranges.
    function automatic logic ovf_model(input int w, input int x, input int y, input int c);
        int sx, sy, s;
        sx = (x >= (1 << (w - 1))) ? x - (1 << w) : x;
        sy = (y >= (1 << (w - 1))) ? y - (1 << w) : y;
        s  = sx + sy + c;
        return (s > (1 << (w - 1)) - 1) || (s < -(1 << (w - 1)));
    endfunction

    task automatic start8(input logic [7:0] x, input logic [7:0] y, input logic c);
        int n = 0;
        while (!in_ready8 && n < 40) begin @(negedge clk); n++; end
        a8 = x; b8 = y; cin8 = c; in_valid8 = 1'b1;
        @(negedge clk);
        in_valid8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    endtask

    task automatic wait_done8(output int lat);
        lat = 0;
        while (!out_valid8 && lat < 40) begin @(negedge clk); lat++; end
    endtask

    task automatic consume8();
        out_ready8 = 1'b1;
        @(negedge clk);
        out_ready8 = 1'b0;
    endtask

    task automatic do_op8(input logic [7:0] x, input logic [7:0] y, input logic c,
                          output logic [8:0] got, output int lat);
        start8(x, y, c);
        wait_done8(lat);
        got = {cout8, sum8};
        consume8();
    endtask

    task automatic op3(input logic [2:0] x, input logic [2:0] y, input logic c,
                       output logic [3:0] got, output logic o, output int lat);
        int n = 0;
        while (!in_ready3 && n < 20) begin @(negedge clk); n++; end
        a3 = x; b3 = y; cin3 = c; in_valid3 = 1'b1;
        @(negedge clk);
        in_valid3 = 1'b0;
        lat = 0;
        while (!out_valid3 && lat < 20) begin @(negedge clk); lat++; end
        got = {cout3, sum3};
        o = ovf3;
        out_ready3 = 1'b1;
        @(negedge clk);
        out_ready3 = 1'b0;
    endtask

    task automatic op1(input logic [0:0] x, input logic [0:0] y, input logic c,
                       output logic [1:0] got, output logic o, output int lat);
        int n = 0;
        while (!in_ready1 && n < 20) begin @(negedge clk); n++; end
        a1 = x; b1 = y; cin1 = c; in_valid1 = 1'b1;
        @(negedge clk);
        in_valid1 = 1'b0;
        lat = 0;
        while (!out_valid1 && lat < 20) begin @(negedge clk); lat++; end
        got = {cout1, sum1};
        o = ovf1;
        out_ready1 = 1'b1;
        @(negedge clk);
        out_ready1 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        total++;
        if ({in_ready8, out_valid8, cout8, sum8, ovf8} !== {1'b1, 1'b0, 1'b0, 8'h00, 1'b0}) begin
            bad++;
            $display("FAIL reset_state: got rdy=%b vld=%b cout=%b sum=%h ovf=%b, want 1 0 0 00 0",
                     in_ready8, out_valid8, cout8, sum8, ovf8);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++;
        if ({in_ready3, out_valid3, in_ready1, out_valid1} !== 4'b1010) begin
            bad++;
            $display("FAIL reset_small: got %b, want 1010",
                     {in_ready3, out_valid3, in_ready1, out_valid1});
        end
    endtask

    task automatic test_directed();
        logic [7:0] va [3] = '{8'hFF, 8'hA5, 8'h12};
        logic [7:0] vb [3] = '{8'h01, 8'h5A, 8'h34};
        logic       vc [3] = '{1'b0, 1'b1, 1'b0};
        logic [8:0] want [3] = '{9'h100, 9'h100, 9'h046};
        logic [8:0] got;
        int lat;
        for (int i = 0; i < 3; i++) begin
            do_op8(va[i], vb[i], vc[i], got, lat);
            total++;
            if (got !== want[i] || lat != 8) begin
                bad++;
                $display("FAIL directed_%0d: got {cout,sum}=%h lat=%0d, want %h lat=8",
                         i, got, lat, want[i]);
            end
            total++;
            if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0) begin
                bad++;
                $display("FAIL handshake_release_%0d: got rdy=%b vld=%b, want 1 0",
                         i, in_ready8, out_valid8);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] x, y;
        logic       c;
        logic [8:0] got, want;
        int lat;
        for (int i = 0; i < 16; i++) begin
            x = 8'($urandom); y = 8'($urandom); c = 1'($urandom);
            want = 9'(x) + 9'(y) + 9'(c);
            do_op8(x, y, c, got, lat);
            total++;
            if (got !== want || lat != 8) begin
                bad++;
                $display("FAIL random_%0d: %h+%h+%b got %h lat=%0d, want %h lat=8",
                         i, x, y, c, got, lat, want);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0] expq [$];
        logic [8:0] want;
        int acc_cyc [3];
        int n_acc = 0, n_res = 0, cyc = 0;
        logic acc;
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
        out_ready8 = 1'b1;
        while (n_res < 3 && cyc < 100) begin
            if (out_valid8) begin
                want = (expq.size() > 0) ? expq.pop_front() : 9'h1FF;
                total++;
                if ({cout8, sum8} !== want) begin
                    bad++;
                    $display("FAIL b2b_result_%0d: got %h, want %h", n_res, {cout8, sum8}, want);
                end
                n_res++;
            end
            in_valid8 = (n_acc < 3);
            acc = in_valid8 && in_ready8;
            if (acc) begin
                expq.push_back(9'(a8) + 9'(b8) + 9'(cin8));
                acc_cyc[n_acc] = cyc;
                n_acc++;
            end
            @(negedge clk);
            cyc++;
            if (acc) begin a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); end
        end
        in_valid8 = 1'b0;
        out_ready8 = 1'b0;
        total++;
        if (n_res != 3) begin
            bad++;
            $display("FAIL b2b_timeout: got %0d results, want 3", n_res);
        end
        for (int i = 1; i < 3; i++) begin
            total++;
            if (n_acc != 3 || acc_cyc[i] - acc_cyc[i-1] != 10) begin
                bad++;
                $display("FAIL b2b_period_%0d: got %0d cycles, want 10", i, acc_cyc[i] - acc_cyc[i-1]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [8:0] want;
        logic [8:0] got;
        int lat;
        want = 9'(8'h9C) + 9'(8'hC3) + 9'd1;
        start8(8'h9C, 8'hC3, 1'b1);
        wait_done8(lat);
        for (int i = 0; i < 5; i++) begin
            in_valid8 = ~in_valid8;
            a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
            @(negedge clk);
            total++;
            if ({cout8, sum8} !== want || in_ready8 !== 1'b0 || out_valid8 !== 1'b1) begin
                bad++;
                $display("FAIL backpressure_%0d: got %h rdy=%b vld=%b, want %h 0 1",
                         i, {cout8, sum8}, in_ready8, out_valid8, want);
            end
        end
        in_valid8 = 1'b0;
        consume8();
        @(negedge clk);
        total++;
        if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1) begin
            bad++;
            $display("FAIL backpressure_release: got vld=%b rdy=%b, want 0 1", out_valid8, in_ready8);
        end
        do_op8(8'h21, 8'h43, 1'b0, got, lat);
        total++;
        if (got !== 9'h064) begin
            bad++;
            $display("FAIL backpressure_next: got %h, want 064", got);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [8:0] got;
        int lat;
        start8(8'hEE, 8'h77, 1'b1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1 || sum8 !== 8'h00 || cout8 !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_run: got vld=%b rdy=%b sum=%h cout=%b, want 0 1 00 0",
                     out_valid8, in_ready8, sum8, cout8);
        end
        @(negedge clk);
        rst = 1'b0;
        do_op8(8'h0F, 8'h01, 1'b0, got, lat);
        total++;
        if (got !== 9'h010 || lat != 8) begin
            bad++;
            $display("FAIL after_reset_op: got %h lat=%0d, want 010 lat=8", got, lat);
        end
    endtask

`ifdef SERIAL_ADDER_OVERFLOW_EN
    task automatic test_overflow();
        logic [7:0] va [2] = '{8'h7F, 8'hFF};
        logic [8:0] want [2] = '{9'h080, 9'h100};
        logic       wo [2] = '{1'b1, 1'b0};
        int lat;
        for (int i = 0; i < 2; i++) begin
            start8(va[i], 8'h01, 1'b0);
            wait_done8(lat);
            total++;
            if ({cout8, sum8} !== want[i] || ovf8 !== wo[i]) begin
                bad++;
                $display("FAIL overflow_%0d: got %h ovf=%b, want %h ovf=%b",
                         i, {cout8, sum8}, ovf8, want[i], wo[i]);
            end
            consume8();
            total++;
            if (ovf8 !== 1'b0) begin
                bad++;
                $display("FAIL overflow_idle_%0d: got %b, want 0", i, ovf8);
            end
        end
    endtask
`endif

    task automatic test_exhaustive_w3();
        logic [3:0] got;
        logic       o;
        int lat, errs = 0;
        for (int v = 0; v < 128; v++) begin
            op3(v[2:0], v[5:3], v[6], got, o, lat);
            total++;
            if (got !== 4'(v[2:0] + v[5:3] + v[6]) || lat != 3) begin
                bad++; errs++;
                if (errs < 5)
                    $display("FAIL w3_%0d: got %h lat=%0d, want %h lat=3",
                             v, got, lat, 4'(v[2:0] + v[5:3] + v[6]));
            end
`ifdef SERIAL_ADDER_OVERFLOW_EN
            total++;
            if (o !== ovf_model(3, int'(v[2:0]), int'(v[5:3]), int'(v[6]))) begin
                bad++;
                $display("FAIL w3_ovf_%0d: got %b", v, o);
            end
`endif
        end
    endtask

    task automatic test_exhaustive_w1();
        logic [1:0] got;
        logic       o;
        int lat;
        for (int v = 0; v < 8; v++) begin
            op1(v[0:0], v[1:1], v[2], got, o, lat);
            total++;
            if (got !== 2'(v[0] + v[1] + v[2]) || lat != 1) begin
                bad++;
                $display("FAIL w1_%0d: got %b lat=%0d, want %b lat=1",
                         v, got, lat, 2'(v[0] + v[1] + v[2]));
            end
`ifdef SERIAL_ADDER_OVERFLOW_EN
            total++;
            if (o !== ovf_model(1, int'(v[0]), int'(v[1]), int'(v[2]))) begin
                bad++;
                $display("FAIL w1_ovf_%0d: got %b", v, o);
            end
`endif
        end
    endtask

    initial begin
        rst = 1'b1;
        {in_valid8, out_ready8, cin8, a8, b8} = '0;
        {in_valid3, out_ready3, cin3, a3, b3} = '0;
        {in_valid1, out_ready1, cin1, a1, b1} = '0;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_run();
`ifdef SERIAL_ADDER_OVERFLOW_EN
        test_overflow();
`endif
        test_exhaustive_w3();
        test_exhaustive_w1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
